// File: rtl/reg_write_arbiter_pkg.sv
// reg_write_arbiter_pkg
//   Shared definitions for the register write arbiter slice:
//   state encoding and a width helper used to size the pointer,
//   owner and burst-counter registers.
package reg_write_arbiter_pkg;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  typedef enum logic {
    STATE_IDLE   = ST_IDLE,
    STATE_LOCKED = ST_LOCKED
  } state_e;

  // ceil(log2(n)), never below 1 so that derived vectors stay legal.
  function automatic int clog2w(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_mkreg.sv
// mkReg
//   Enabled storage register with synchronous active-low reset to INIT.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   en_i   load enable
//   d_i    [WIDTH] load value
//   q_o    [WIDTH] stored value
module mkReg #(
  parameter int                WIDTH = 32,
  parameter logic [WIDTH-1:0]  INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= INIT;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/reg_write_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Searches req_i starting at index
//   ptr_i and wrapping at NREQ; the first requester found wins.
// Ports:
//   req_i  [NREQ]  request vector
//   ptr_i  [PW]    search start index (must be < NREQ)
//   gnt_o  [NREQ]  one-hot grant, or zero when nothing requests
//   idx_o  [PW]    index of the winner (0 when gnt_o is zero)
module rr_pick
  import reg_write_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = clog2w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o
);

  // Scan from the farthest candidate back to ptr_i so the last hit
  // written is the closest one to the pointer.
  always_comb begin
    int j;
    gnt_o = '0;
    idx_o = '0;
    j     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Shares one storage register between NREQ writers. A round-robin
//   arbiter grants at most one writer per cycle; a writer holding lock
//   keeps the register for up to MAX_BURST consecutive beats.
// Ports:
//   clk    clock, all state on posedge
//   rst_n  synchronous active-low reset
//   req    [NREQ]        write requests (held until granted)
//   lock   [NREQ]        burst-lock requests, qualified by req
//   wdata  [NREQ*WIDTH]  write data, requester i at [i*WIDTH +: WIDTH]
//   gnt    [NREQ]        combinational one-hot grant; write lands next edge
//   q      [WIDTH]       stored register value
//   owner  [clog2(NREQ)] last granted requester / current lock holder
//   busy                 high while a lock is held
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int               NREQ      = 4,
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] INIT      = '0,
  parameter int               MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         lock,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        q,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy
);

  localparam int PW = clog2w(NREQ);
  localparam int CW = clog2w(MAX_BURST + 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   owner_q, owner_d;

  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   widx;
  logic [WIDTH-1:0] wsel;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  always_comb begin
    gnt     = '0;
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    widx    = pick_idx;
    // Grants are suppressed during reset so no write competes with it.
    if (rst_n) begin
      case (state_q)
        STATE_IDLE: begin
          gnt  = pick_gnt;
          widx = pick_idx;
          if (|pick_gnt) begin
            ptr_d   = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
            owner_d = pick_idx;
            if (lock[pick_idx] && (MAX_BURST > 1)) begin
              cnt_d   = CW'(1);
              state_d = STATE_LOCKED;
            end
          end
        end
        STATE_LOCKED: begin
          // Only the owner can be served; ptr already points past it.
          widx = owner_q;
          if (req[owner_q]) begin
            gnt[owner_q] = 1'b1;
            if (lock[owner_q] && ((int'(cnt_q) + 1) < MAX_BURST)) begin
              cnt_d = cnt_q + CW'(1);
            end else begin
              cnt_d   = '0;
              state_d = STATE_IDLE;
            end
          end else begin
            // Owner walked away: release the lock, this cycle is lost.
            cnt_d   = '0;
            state_d = STATE_IDLE;
          end
        end
        default: state_d = STATE_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= STATE_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

  assign wsel = wdata[int'(widx)*WIDTH +: WIDTH];

  mkReg #(
    .WIDTH (WIDTH),
    .INIT  (INIT)
  ) u_store (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (|gnt),
    .d_i   (wsel),
    .q_o   (q)
  );

  assign busy  = (state_q == STATE_LOCKED);
  assign owner = owner_q;

endmodule
